// File: rtl/vdmem_pkg.sv
// Shared types for the vector data memory arbiter: lane count, the 6x8 memory word
// and the arbitration state encoding.
package vdmem_pkg;

  localparam int VLANES = 6;

  typedef logic [VLANES-1:0][7:0] vword_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    YIELD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating wait counter for the loader port: counts ungranted request cycles and
// flags when the wait has reached LIMIT so the arbiter can force a grant.
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  assign hit = (count == W'(LIMIT));

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !hit) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/vdmem_arbiter.sv
// Shares the single data_mem_vect port between the pipeline MEM stage (C, priority) and the
// RSA block loader (D, burst-capable), with a starvation guard for D and a burst cap for C.
module vdmem_arbiter
  import vdmem_pkg::*;
#(
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  vword_t      c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output vword_t      c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_lock,
  input  logic [31:0] d_addr,
  input  vword_t      d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output vword_t      d_rdata,
  output logic        mem_WE,
  output logic [31:0] mem_A,
  output vword_t      mem_WD,
  input  vword_t      mem_RD
);

  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t    state, state_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt, burst_inc;
  logic          starve_hit;

  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (d_req && !d_gnt),
    .clr (d_gnt),
    .hit (starve_hit)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && starve_hit) d_gnt = 1'b1;
        else if (c_req)          c_gnt = 1'b1;
        else                     d_gnt = d_req;
      end
      BURST: begin
        d_gnt = d_req;
        c_gnt = c_req && !d_req;
      end
      YIELD:   c_gnt = c_req;
      default: ;
    endcase
  end

  always_comb begin
    mem_WE = 1'b0;
    mem_A  = '0;
    mem_WD = '0;
    if (c_gnt) begin
      mem_WE = c_we;
      mem_A  = c_addr;
      mem_WD = c_wdata;
    end else if (d_gnt) begin
      mem_WE = d_we;
      mem_A  = d_addr;
      mem_WD = d_wdata;
    end
  end

  assign burst_inc = burst_cnt + BW'(1);

  // The cap is checked on the beat that completes it, so D never gets a (MAX_BURST+1)th beat.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (d_gnt && d_lock) begin
          state_nxt = BURST;
          burst_nxt = BW'(1);
        end
      end
      BURST: begin
        if (!d_lock || !d_req) begin
          state_nxt = IDLE;
          burst_nxt = '0;
        end else if (burst_inc == BW'(MAX_BURST)) begin
          burst_nxt = '0;
          if (c_req) state_nxt = YIELD;
        end else begin
          burst_nxt = burst_inc;
        end
      end
      YIELD: begin
        state_nxt = IDLE;
        burst_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Read data is captured on the grant edge; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt && !c_we;
      d_rvalid <= d_gnt && !d_we;
      if (c_gnt && !c_we) c_rdata <= mem_RD;
      if (d_gnt && !d_we) d_rdata <= mem_RD;
    end
  end

endmodule

// File: tb/tb_vdmem_arbiter.sv
// Bench for vdmem_arbiter with a behavioural data_mem_vect behind it and a reference
// arbitration/memory model driving every expected value.
module tb_vdmem_arbiter;
  import vdmem_pkg::*;

  localparam int MAX_BURST    = 8;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, d_addr;
  vword_t      c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  vword_t      c_rdata, d_rdata;
  logic        mem_WE;
  logic [31:0] mem_A;
  vword_t      mem_WD, mem_RD;

  always #5 clk = ~clk;

  vdmem_arbiter #(.MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  // data_mem_vect stand-in: combinational read, write on the clock edge
  vword_t mem_arr [0:63];
  logic   mem_clear;
  assign mem_RD = mem_arr[mem_A[7:2]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= '0;
    end else if (mem_WE) begin
      mem_arr[mem_A[7:2]] <= mem_WD;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        c_req, c_we;
    logic [31:0] c_addr;
    vword_t      c_wd;
    logic        d_req, d_we, d_lock;
    logic [31:0] d_addr;
    vword_t      d_wd;
  } stim_t;

  typedef struct {
    logic c_req, d_req;
    logic exp_c, exp_d;
  } vec_t;

  // Reference model: wait length of D, beats taken in the current burst, pending yield
  int     m_wait, m_beats;
  bit     m_burst, m_yield;
  vword_t ref_mem [0:63];
  logic   e_crv, e_drv;
  vword_t e_crd, e_drd;

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst = 1'b0; s.c_req = 1'b0; s.c_we = 1'b0; s.c_addr = '0; s.c_wd = '0;
    s.d_req = 1'b0; s.d_we = 1'b0; s.d_lock = 1'b0; s.d_addr = '0; s.d_wd = '0;
    return s;
  endfunction

  function automatic vword_t rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  task automatic run_cycle(input stim_t s, output logic gc, output logic gd);
    logic        ec, ed, ewe;
    logic [31:0] ea;
    vword_t      ewd;
    @(negedge clk);
    rst = s.rst; c_req = s.c_req; c_we = s.c_we; c_addr = s.c_addr; c_wdata = s.c_wd;
    d_req = s.d_req; d_we = s.d_we; d_lock = s.d_lock; d_addr = s.d_addr; d_wdata = s.d_wd;
    #1;
    ec = 1'b0;
    ed = 1'b0;
    if (m_yield) ec = s.c_req;
    else if (m_burst) begin
      ed = s.d_req;
      ec = s.c_req && !s.d_req;
    end else if (s.d_req && m_wait >= STARVE_LIMIT) ed = 1'b1;
    else if (s.c_req) ec = 1'b1;
    else ed = s.d_req;
    ewe = ec ? s.c_we   : (ed ? s.d_we   : 1'b0);
    ea  = ec ? s.c_addr : (ed ? s.d_addr : 32'd0);
    ewd = ec ? s.c_wd   : (ed ? s.d_wd   : vword_t'('0));
    check("c_gnt", c_gnt, ec);
    check("d_gnt", d_gnt, ed);
    check("gnt_exclusive", c_gnt & d_gnt, 64'd0);
    check("mem_WE", mem_WE, ewe);
    check("mem_A", mem_A, ea);
    check("mem_WD", mem_WD, ewd);
    gc = c_gnt;
    gd = d_gnt;
    e_crv = ec && !s.c_we;
    e_drv = ed && !s.d_we;
    if (e_crv) e_crd = ref_mem[s.c_addr[7:2]];
    if (e_drv) e_drd = ref_mem[s.d_addr[7:2]];
    if (ewe) ref_mem[ea[7:2]] = ewd;
    if (ed) m_wait = 0;
    else if (s.d_req && m_wait < STARVE_LIMIT) m_wait++;
    if (m_yield) m_yield = 1'b0;
    else if (m_burst) begin
      if (!s.d_lock || !s.d_req) begin
        m_burst = 1'b0;
        m_beats = 0;
      end else begin
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_beats = 0;
          if (s.c_req) begin
            m_burst = 1'b0;
            m_yield = 1'b1;
          end
        end
      end
    end else if (ed && s.d_lock) begin
      m_burst = 1'b1;
      m_beats = 1;
    end
    if (s.rst) begin
      m_wait = 0; m_beats = 0; m_burst = 1'b0; m_yield = 1'b0;
      e_crv = 1'b0; e_drv = 1'b0; e_crd = '0; e_drd = '0;
    end
    @(posedge clk);
    #1;
    check("c_rvalid", c_rvalid, e_crv);
    check("c_rdata", c_rdata, e_crd);
    check("d_rvalid", d_rvalid, e_drv);
    check("d_rdata", d_rdata, e_drd);
  endtask

  initial begin
    stim_t  s;
    logic   gc, gd;
    vec_t   tbl [6];
    vword_t pattern;
    int     d_beats, run, first_run, rv, cyc;
    bit     first_done, yield_seen;

    rst = 1'b1; mem_clear = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    m_wait = 0; m_beats = 0; m_burst = 0; m_yield = 0;
    e_crv = 0; e_drv = 0; e_crd = '0; e_drd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_clear = 1'b0;
    check("reset_c_rvalid", c_rvalid, 64'd0);
    check("reset_d_rdata", d_rdata, 64'd0);

    // Idle ports: no grants, no writes, no read data
    for (int i = 0; i < 3; i++) run_cycle(idle_stim(), gc, gd);

    // C write then read back at address 0
    pattern = 48'h001122334455;
    s = idle_stim(); s.c_req = 1; s.c_we = 1; s.c_addr = 32'h0; s.c_wd = pattern;
    run_cycle(s, gc, gd);
    s.c_we = 0;
    run_cycle(s, gc, gd);
    check("t1_rvalid", c_rvalid, 64'd1);
    check("t1_rdata", c_rdata, pattern);

    // Starvation guard: both request, D forced in on the fifth cycle
    tbl[0] = '{1, 1, 1, 0}; tbl[1] = '{1, 1, 1, 0}; tbl[2] = '{1, 1, 1, 0};
    tbl[3] = '{1, 1, 1, 0}; tbl[4] = '{1, 1, 0, 1}; tbl[5] = '{1, 1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      s = idle_stim();
      s.c_req = tbl[i].c_req; s.c_addr = 32'h0;
      s.d_req = tbl[i].d_req; s.d_addr = 32'h4;
      run_cycle(s, gc, gd);
      check($sformatf("t2_c_gnt[%0d]", i), gc, tbl[i].exp_c);
      check($sformatf("t2_d_gnt[%0d]", i), gd, tbl[i].exp_d);
    end

    // Locked D burst of 10 writes against a continuous C request
    d_beats = 0; run = 0; first_run = 0; first_done = 0; yield_seen = 0; cyc = 0;
    while (d_beats < 10 && cyc < 60) begin
      s = idle_stim();
      s.c_req = 1; s.c_addr = 32'h40;
      s.d_req = 1; s.d_we = 1; s.d_lock = 1;
      s.d_addr = 32'(d_beats * 4); s.d_wd = rand_word();
      run_cycle(s, gc, gd);
      cyc++;
      if (gd) begin
        d_beats++;
        run++;
      end else begin
        if (!first_done && run > 0) begin
          first_done = 1;
          first_run  = run;
          yield_seen = gc;
        end
        run = 0;
      end
    end
    check("t3_all_beats", d_beats, 64'd10);
    check("t3_burst_len", first_run, 64'd8);
    check("t3_yield_to_c", yield_seen, 64'd1);
    run_cycle(idle_stim(), gc, gd);

    // Back-to-back D reads of the burst data
    rv = 0;
    for (int i = 1; i <= 4; i++) begin
      s = idle_stim(); s.d_req = 1; s.d_addr = 32'(i * 4);
      run_cycle(s, gc, gd);
      if (d_rvalid) rv++;
    end
    check("t4_rvalid_run", rv, 64'd4);
    run_cycle(idle_stim(), gc, gd);

    // Reset in the middle of a burst with a read in flight
    s = idle_stim(); s.d_req = 1; s.d_lock = 1; s.d_addr = 32'h8;
    run_cycle(s, gc, gd);
    s.rst = 1; s.d_addr = 32'hC;
    run_cycle(s, gc, gd);
    check("t5_d_rvalid", d_rvalid, 64'd0);
    check("t5_d_rdata", d_rdata, 64'd0);
    run_cycle(idle_stim(), gc, gd);
    s = idle_stim(); s.c_req = 1; s.d_req = 1; s.d_lock = 1; s.d_addr = 32'h10;
    run_cycle(s, gc, gd);
    check("t5_idle_c_wins", gc, 64'd1);

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      s.rst    = ($urandom_range(0, 99) == 0);
      s.c_req  = 1'($urandom_range(0, 1));
      s.c_we   = 1'($urandom_range(0, 1));
      s.c_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      s.c_wd   = rand_word();
      s.d_req  = ($urandom_range(0, 3) != 0);
      s.d_we   = 1'($urandom_range(0, 1));
      s.d_lock = ($urandom_range(0, 3) != 0);
      s.d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      s.d_wd   = rand_word();
      run_cycle(s, gc, gd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
